cam_bus_emulator: RTL

Transmitter side of the camera parallel pixel bus. Generates an OV7670-style RGB565 byte stream so the capture, M9K and image-processor path can run on the board or in simulation without a real camera:

- a free-running pixel clock
- VSYNC and HREF framing
- 8-bit data

Pixel content comes from an internal pattern generator. Outputs drive the same GPIO pins the capture logic samples.

---
 rtl/cam_bus_emulator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cam_bus_emulator.sv
// cam_bus_emulator: OV7670-style RGB565 camera bus source (PCLK, VSYNC, HREF, DATA)
// fed by an internal pattern generator; framing outputs change only on PCLK falling edges.
module cam_bus_emulator #(
    parameter int WIDTH        = 176,
    parameter int HEIGHT       = 144,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP_LINES    = 17,
    parameter int VFP_LINES    = 10,
    parameter int HBLANK_BYTES = 144
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [1:0]  MODE,
    input  logic [15:0] COLOR,
    output logic        PCLK_OUT,
    output logic        VSYNC_OUT,
    output logic        HREF_OUT,
    output logic [7:0]  DATA_OUT,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [7:0]  FRAME_CNT
);
    localparam logic [15:0] LAST_BYTE = 16'(2 * WIDTH + HBLANK_BYTES - 1);
    localparam logic [15:0] ACT_BYTES = 16'(2 * WIDTH);
    localparam logic [15:0] BAR_LAST  = 16'(WIDTH / 8 - 1);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t      state_q, state_d;
    logic [15:0] byte_q, byte_d, line_q, line_d, bar_sub_q, bar_sub_d, n_lines;
    logic [15:0] color_q, color_d, pix;
    logic [2:0]  bar_q, bar_d;
    logic [1:0]  mode_q, mode_d;
    logic [4:0]  x_d;
    logic [7:0]  data_q, data_d, cnt_q;
    logic        pclk_q, vsync_q, href_q, busy_q, done_q;
    logic        last_byte, last_line, frame_end, href_d, new_pix;

    // Everything with a _d suffix describes the byte-time that starts at the next PCLK fall.
    always_comb begin
        n_lines   = (state_q == VSYNC)  ? 16'(VSYNC_LINES) :
                    (state_q == VBACK)  ? 16'(VBP_LINES)   :
                    (state_q == ACTIVE) ? 16'(HEIGHT)      : 16'(VFP_LINES);
        last_byte = byte_q == LAST_BYTE;
        last_line = line_q == n_lines - 16'd1;
        frame_end = state_q == VFRONT && last_byte && last_line;
        state_d   = state_q;
        byte_d    = last_byte ? 16'd0 : byte_q + 16'd1;
        line_d    = line_q;
        mode_d    = mode_q;
        color_d   = color_q;
        if (state_q == IDLE) begin
            byte_d = 16'd0;
            if (ENABLE) state_d = VSYNC;
        end else if (last_byte) begin
            line_d = last_line ? 16'd0 : line_q + 16'd1;
            if (last_line)
                state_d = (state_q == VSYNC)  ? VBACK  :
                          (state_q == VBACK)  ? ACTIVE :
                          (state_q == ACTIVE) ? VFRONT :
                          ENABLE ? VSYNC : IDLE;
        end
        if (state_d == VSYNC && state_q != VSYNC) begin
            mode_d  = MODE;
            color_d = COLOR;
        end
        // Colour-bar index tracked by a pixel sub-counter so no divider is needed.
        new_pix   = !byte_d[0] && bar_sub_q == BAR_LAST;
        bar_sub_d = (byte_d == 16'd0 || new_pix) ? 16'd0 : !byte_d[0] ? bar_sub_q + 16'd1 : bar_sub_q;
        bar_d     = (byte_d == 16'd0) ? 3'd0 : new_pix ? bar_q + 3'd1 : bar_q;
        x_d       = byte_d[5:1];
        pix       = (mode_d == 2'd0) ? color_d :
                    (mode_d == 2'd1) ? BARS[bar_d] :
                    (mode_d == 2'd2) ? {x_d, 11'd0} :
                    (x_d[3] ^ line_d[3]) ? 16'hFFFF : 16'h0000;
        href_d    = state_d == ACTIVE && byte_d < ACT_BYTES;
        data_d    = href_d ? (byte_d[0] ? pix[7:0] : pix[15:8]) : 8'd0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pclk_q    <= 1'b0;
            state_q   <= IDLE;
            byte_q    <= 16'd0;
            line_q    <= 16'd0;
            bar_sub_q <= 16'd0;
            bar_q     <= 3'd0;
            mode_q    <= 2'd0;
            color_q   <= 16'd0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            data_q    <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            pclk_q <= ~pclk_q;
            done_q <= !pclk_q && frame_end;
            if (!pclk_q && frame_end) cnt_q <= cnt_q + 8'd1;
            if (pclk_q) begin
                state_q   <= state_d;
                byte_q    <= byte_d;
                line_q    <= line_d;
                bar_sub_q <= bar_sub_d;
                bar_q     <= bar_d;
                mode_q    <= mode_d;
                color_q   <= color_d;
                vsync_q   <= state_d == VSYNC;
                href_q    <= href_d;
                data_q    <= data_d;
                busy_q    <= state_d != IDLE;
            end
        end
    end

    assign PCLK_OUT   = pclk_q;
    assign VSYNC_OUT  = vsync_q;
    assign HREF_OUT   = href_q;
    assign DATA_OUT   = data_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign FRAME_CNT  = cnt_q;
endmodule
